// File: rtl/pixel_bus_pkg.sv
// Shared definitions for the pixel bus receiver.
//   - Default screen geometry (SCREEN_W_DEF x SCREEN_H_DEF).
//   - TRANSPARENT_KEY: the magenta colour key that the optional
//     PIXEL_RX_TRANSPARENT_KEY_EN build discards before the FIFO.
//   - rx_state_t: receiver FSM encoding (S_IDLE, S_CLEAR, S_DONE).
//   - channel_bits(): bits kept per RGB channel for a framebuffer depth.
package pixel_bus_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [23:0] TRANSPARENT_KEY = 24'hFF00FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } rx_state_t;

  // The framebuffer colour is split evenly across R, G and B.
  function automatic int channel_bits(input int colour_bits);
    return colour_bits / 3;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: the oldest entry is always visible on head.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push, data  : write request and write data
//   pop         : read request (ignored while empty)
//   head        : oldest entry (don't-care while empty)
//   full, empty : occupancy flags
//   count       : occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; stale data is never visible because head is
  // only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_bus_receiver.sv
// Sink of the shared pixel draw bus. Each strobe is registered, clipped to
// the screen, reduced to framebuffer colour depth and queued; the queue is
// drained into the framebuffer write port. A clear request fills the whole
// screen with a latched colour once the queue has drained.
//
// Optional build macro: PIXEL_RX_TRANSPARENT_KEY_EN -- when defined, on-screen
// pixels whose colour equals 24'hFF00FF are dropped silently.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   draw_enable_bus   : bus strobe; only a clean 1 counts
//   x_bus, y_bus      : pixel coordinates
//   rgb_bus           : {R,G,B} 8 bits each
//   clear_req         : single-cycle clear request
//   clear_colour      : fill colour, captured when clear_req is accepted
//   fb_ready          : framebuffer accepts the presented write
//   fb_write          : write valid
//   fb_address        : write address (y*SCREEN_W + x)
//   fb_colour         : write data
//   fifo_count        : queue occupancy
//   overflow          : sticky, a pixel was dropped on a full queue
//   clipped           : one-cycle pulse for an off-screen strobe
//   clear_done        : one-cycle pulse when the clear finishes
//   busy              : queue non-empty or FSM not idle
//   fsm_state         : current FSM state (rx_state_t encoding), debug only
//
// Handshake: a write transfers on a rising edge where fb_write and fb_ready
// are both high. While fb_write is high and fb_ready low, fb_address and
// fb_colour hold their values; fb_write is never withdrawn before transfer.
module pixel_bus_receiver
  import pixel_bus_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int COLOUR_BITS = 9,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_BITS   = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          draw_enable_bus,
  input  logic [7:0]                    x_bus,
  input  logic [7:0]                    y_bus,
  input  logic [23:0]                   rgb_bus,
  input  logic                          clear_req,
  input  logic [COLOUR_BITS-1:0]        clear_colour,
  input  logic                          fb_ready,
  output logic                          fb_write,
  output logic [ADDR_BITS-1:0]          fb_address,
  output logic [COLOUR_BITS-1:0]        fb_colour,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          clipped,
  output logic                          clear_done,
  output logic                          busy,
  output logic [1:0]                    fsm_state
);

  localparam int K          = channel_bits(COLOUR_BITS);
  localparam int ENTRY_BITS = ADDR_BITS + COLOUR_BITS;
  localparam int PIXELS     = SCREEN_W * SCREEN_H;

  localparam logic [8:0]           W_LIMIT   = 9'(SCREEN_W);
  localparam logic [8:0]           H_LIMIT   = 9'(SCREEN_H);
  localparam logic [ADDR_BITS-1:0] W_ADDR    = ADDR_BITS'(SCREEN_W);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXELS - 1);

  // ---------------------------------------------------------------- input stage
  logic        in_strobe;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [23:0] in_rgb;

  // X or Z on the shared strobe line must not be taken as a draw, hence the
  // case-equality test.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_strobe <= 1'b0;
      in_x      <= '0;
      in_y      <= '0;
      in_rgb    <= '0;
    end else begin
      in_strobe <= (draw_enable_bus === 1'b1);
      in_x      <= x_bus;
      in_y      <= y_bus;
      in_rgb    <= rgb_bus;
    end
  end

  logic                   on_screen;
  logic                   is_key;
  logic                   push_req;
  logic [ADDR_BITS-1:0]   pixel_addr;
  logic [COLOUR_BITS-1:0] pixel_colour;

  assign on_screen    = ({1'b0, in_x} < W_LIMIT) && ({1'b0, in_y} < H_LIMIT);
  assign pixel_addr   = ADDR_BITS'(in_y) * W_ADDR + ADDR_BITS'(in_x);
  assign pixel_colour = {in_rgb[23 -: K], in_rgb[15 -: K], in_rgb[7 -: K]};

`ifdef PIXEL_RX_TRANSPARENT_KEY_EN
  assign is_key = (in_rgb == TRANSPARENT_KEY);
`else
  assign is_key = 1'b0;
`endif

  assign push_req = in_strobe && on_screen && !is_key;

  // ---------------------------------------------------------------- queue
  logic [ENTRY_BITS-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  pixel_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .data  ({pixel_addr, pixel_colour}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- FSM
  rx_state_t              state;
  rx_state_t              next_state;
  logic                   clear_pending;
  logic [COLOUR_BITS-1:0] clear_col;
  logic [ADDR_BITS-1:0]   clear_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fb_write   = 1'b0;
    fb_address = '0;
    fb_colour  = '0;
    fifo_pop   = 1'b0;
    clear_done = 1'b0;
    case (state)
      S_IDLE: begin
        fb_write = !fifo_empty;
        if (!fifo_empty) begin
          fb_address = fifo_head[ENTRY_BITS-1 -: ADDR_BITS];
          fb_colour  = fifo_head[COLOUR_BITS-1:0];
        end
        fifo_pop = !fifo_empty && fb_ready;
        // Queued pixels are written before the clear starts.
        if (clear_pending && fifo_empty) begin
          next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fb_write   = 1'b1;
        fb_address = clear_cnt;
        fb_colour  = clear_col;
        if (fb_ready && (clear_cnt == LAST_ADDR)) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        clear_done = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_pending <= 1'b0;
      clear_col     <= '0;
      clear_cnt     <= '0;
      overflow      <= 1'b0;
      clipped       <= 1'b0;
    end else begin
      clipped <= in_strobe && !on_screen;
      // A full queue still accepts a push when the same edge pops an entry.
      if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
      // The pending flag is consumed as the FSM enters S_CLEAR; a request
      // during a pending or running clear is ignored.
      if (state == S_IDLE && clear_pending && fifo_empty) begin
        clear_pending <= 1'b0;
      end else if (clear_req && !clear_pending && state != S_CLEAR) begin
        clear_pending <= 1'b1;
        clear_col     <= clear_colour;
      end
      if (state == S_CLEAR) begin
        if (fb_ready) begin
          clear_cnt <= clear_cnt + 1'b1;
        end
      end else begin
        clear_cnt <= '0;
      end
    end
  end

  assign busy      = !fifo_empty || (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_pixel_bus_receiver.sv
module tb_pixel_bus_receiver;

  localparam int SW     = 160;
  localparam int SH     = 120;
  localparam int DEPTH  = 8;
  localparam int PIXELS = SW * SH;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        draw_enable_bus = 1'b0;
  logic [7:0]  x_bus = '0;
  logic [7:0]  y_bus = '0;
  logic [23:0] rgb_bus = '0;
  logic        clear_req = 1'b0;
  logic [8:0]  clear_colour = '0;
  logic        fb_ready = 1'b0;
  logic        fb_write;
  logic [14:0] fb_address;
  logic [8:0]  fb_colour;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clipped;
  logic        clear_done;
  logic        busy;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  pixel_bus_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .draw_enable_bus (draw_enable_bus),
    .x_bus           (x_bus),
    .y_bus           (y_bus),
    .rgb_bus         (rgb_bus),
    .clear_req       (clear_req),
    .clear_colour    (clear_colour),
    .fb_ready        (fb_ready),
    .fb_write        (fb_write),
    .fb_address      (fb_address),
    .fb_colour       (fb_colour),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .clipped         (clipped),
    .clear_done      (clear_done),
    .busy            (busy),
    .fsm_state       (fsm_state)
  );

  // ---------------------------------------------------------------- model state
  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] exp_q[$];      // {address[14:0], colour[8:0]} in write order
  int          occ = 0;       // pixels held in the receiver queue
  bit          ovf_m = 0;
  bit          clear_active = 0;
  int          done_count = 0;

  typedef struct {
    bit          s;
    int          x;
    int          y;
    logic [23:0] rgb;
  } px_t;

  px_t hist1;                 // bus applied one cycle ago
  px_t hist2;                 // bus applied two cycles ago (pushes this edge)

  function automatic logic [14:0] ref_addr(input int x, input int y);
    return 15'(y * SW + x);
  endfunction

  function automatic logic [8:0] ref_colour(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    return 9'((r / 32) * 64 + (g / 32) * 8 + (b / 32));
  endfunction

  function automatic bit ref_is_key(input logic [23:0] rgb);
`ifdef PIXEL_RX_TRANSPARENT_KEY_EN
    return rgb == 24'hFF00FF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // One call per clock: first account for the edge that just happened, then
  // compare the DUT against the model, then apply the next inputs.
  task automatic cycle(input bit s, input int x, input int y, input logic [23:0] rgb,
                       input bit rdy, input bit clr, input logic [8:0] ccol);
    bit pop;
    bit on;
    @(posedge clk);
    #1;
    pop = (occ > 0) && fb_ready;
    on  = hist2.s && (hist2.x < SW) && (hist2.y < SH);
    if (on && !ref_is_key(hist2.rgb)) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back({ref_addr(hist2.x, hist2.y), ref_colour(hist2.rgb)});
        occ++;
      end else begin
        ovf_m = 1;
      end
    end
    if (pop) occ--;
    check("fifo_count", fifo_count, occ);
    check("overflow", overflow, ovf_m);
    check("clipped", clipped, hist2.s && !((hist2.x < SW) && (hist2.y < SH)));
    if (!clear_active) begin
      check("fb_write", fb_write, occ > 0);
      check("busy", busy, occ > 0);
    end
    hist2 = hist1;
    hist1.s = s; hist1.x = x; hist1.y = y; hist1.rgb = rgb;
    draw_enable_bus = s;
    x_bus           = 8'(x);
    y_bus           = 8'(y);
    rgb_bus         = rgb;
    fb_ready        = rdy;
    clear_req       = clr;
    clear_colour    = ccol;
    if (clr) begin
      clear_active = 1;
      for (int i = 0; i < PIXELS; i++) exp_q.push_back({15'(i), ccol});
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 24'h0, rdy, 0, 9'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ = 0;
    ovf_m = 0;
    clear_active = 0;
    hist1.s = 0; hist1.x = 0; hist1.y = 0; hist1.rgb = '0;
    hist2 = hist1;
  endtask

  task automatic check_reset_values();
    check("rst_fb_write", fb_write, 0);
    check("rst_fb_address", fb_address, 0);
    check("rst_fb_colour", fb_colour, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_clipped", clipped, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_busy", busy, 0);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (fb_write && fb_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", fb_address, 15'h7fff);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("fb_address", fb_address, e[23:9]);
          check("fb_colour", fb_colour, e[8:0]);
        end
      end
      if (clear_done) begin
        done_count++;
        check("clear_done_after_last_write", exp_q.size(), 0);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit found;
    int d0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;

    // Single pixel: address 323, colour 111_100_010, two cycles of latency.
    cycle(1, 3, 2, 24'hFF8040, 1, 0, 9'h0);
    idle(4, 1);

    // Off-screen strobe: clipped pulse only.
    cycle(1, 160, 5, 24'h123456, 1, 0, 9'h0);
    idle(4, 1);

    // Magenta key: dropped with the key build, written as 111_000_111 otherwise.
    cycle(1, 10, 10, 24'hFF00FF, 1, 0, 9'h0);
    idle(4, 1);

    // Backpressure: 10 strobes into an 8-deep queue.
    for (int i = 0; i < 10; i++) cycle(1, 20 + i, 30, 24'h204060 + 24'(i * 24'h010101), 0, 0, 9'h0);
    idle(2, 0);
    check("bp_fifo_count_full", fifo_count, 8);
    check("bp_overflow_set", overflow, 1);
    idle(12, 1);

    // Clear with two queued pixels.
    cycle(1, 1, 1, 24'hE0E0E0, 0, 0, 9'h0);
    cycle(1, 159, 119, 24'h00FF00, 0, 0, 9'h0);
    idle(3, 0);
    d0 = done_count;
    cycle(0, 0, 0, 24'h0, 1, 1, 9'h0AA);
    for (int i = 0; i < 25000 && done_count == d0; i++) begin
      cycle(0, 0, 0, 24'h0, 1, 0, 9'h0);
    end
    check("clear_done_seen", done_count - d0, 1);
    idle(3, 1);
    clear_active = 0;
    idle(2, 1);
    check("clear_done_single", done_count - d0, 1);

    // Reset in the middle of a clear.
    cycle(0, 0, 0, 24'h0, 1, 1, 9'h155);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle(0, 0, 0, 24'h0, 1, 0, 9'h0);
      if (fb_write && fb_address == 15'd500) begin
        found = 1;
        break;
      end
    end
    check("reach_clear_addr_500", found, 1);
    reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    draw_enable_bus = 0;
    clear_req = 0;
    d0 = done_count;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(30, 1);
    check("no_clear_done_after_reset", done_count, d0);

    // Randomized traffic: a low-ready phase that overflows, then a high-ready phase.
    for (int i = 0; i < 1500; i++) begin
      bit          s;
      bit          rdy;
      logic [23:0] rgb;
      s   = ($urandom_range(0, 9) < 6);
      rgb = ($urandom_range(0, 9) == 0) ? 24'hFF00FF : 24'($urandom);
      rdy = (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(s, $urandom_range(0, 175), $urandom_range(0, 127), rgb, rdy, 0, 9'h0);
    end
    idle(20, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_bus_receiver.md
Name:
pixel_bus_receiver

Overview:
- Sink end of the shared tri-stated pixel draw bus that tile/sprite drawers drive: draw enable, x, y, 24-bit RGB.
- Samples each draw strobe, clips it to the screen, reduces the colour to framebuffer depth and queues it in a small FIFO.
- Drains the FIFO into the framebuffer write port using a valid/ready handshake.
- Also provides a full-screen clear sequence so the game loop can wipe the frame before redrawing tiles.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- COLOUR_BITS, 9, framebuffer colour width. Must be a multiple of 3.
- FIFO_DEPTH, 8, pixel queue entries. Must be a power of 2.
- ADDR_BITS, 15, framebuffer address width. Must be at least ceil(log2(SCREEN_W*SCREEN_H)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- draw_enable_bus  in  1  pixel strobe from the shared bus. Only 1'b1 counts as a strobe; 0, X and Z are all treated as no strobe.
- x_bus  in  8  pixel x from the bus.
- y_bus  in  8  pixel y from the bus.
- rgb_bus  in  24  {R[7:0],G[7:0],B[7:0]} from the bus.
- clear_req  in  1  single-cycle request to fill the screen with clear_colour.
- clear_colour  in  COLOUR_BITS  fill value, sampled on the cycle clear_req is accepted.
- fb_ready  in  1  framebuffer accepts a write this cycle.
- fb_write  out  1  framebuffer write valid.
- fb_address  out  ADDR_BITS  framebuffer write address.
- fb_colour  out  COLOUR_BITS  framebuffer write data.
- fifo_count  out  log2(FIFO_DEPTH)+1  current queue occupancy.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- clipped  out  1  one-cycle pulse: a strobed pixel was off-screen.
- clear_done  out  1  one-cycle pulse when the clear sequence completes.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in S_IDLE.

Behaviour:
- Reset values: fb_write=0, fb_address=0, fb_colour=0, fifo_count=0, overflow=0, clipped=0, clear_done=0, busy=0. FSM goes to S_IDLE; the FIFO and any pending clear are discarded. Reset is legal at any point, including mid-clear or mid-handshake.
- Input stage:
  - At each posedge, register {strobe, x, y, rgb} from the bus.
  - On the next edge, a registered strobe pushes one entry if x<SCREEN_W and y<SCREEN_H.
  - An off-screen pixel is not pushed; clipped pulses for one cycle instead.
- Entry format:
  - address = y*SCREEN_W + x, computed at ADDR_BITS width.
  - colour = {R[7:8-k], G[7:8-k], B[7:8-k]}, where k = COLOUR_BITS/3 (top k bits of each channel).
- Full/empty rules:
  - A push while full with no simultaneous pop drops the pixel and sets overflow; overflow stays high until reset.
  - A push and a pop in the same cycle while full: the pop frees space and the push is accepted.
  - A pop while empty is impossible, because fb_write is low whenever the FIFO is empty.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - S_IDLE: fb_write = FIFO non-empty. fb_address and fb_colour come combinationally from the FIFO head. Pop when fb_write && fb_ready. If clear_req arrives, latch a pending clear and clear_colour. When a clear is pending and the FIFO is empty, go to S_CLEAR with clear counter = 0.
  - S_CLEAR: fb_write=1, fb_address = counter, fb_colour = latched colour. Increment the counter on fb_ready. When fb_ready arrives at counter = SCREEN_W*SCREEN_H-1, go to S_DONE. Bus pixels keep queueing during this state but are not drained; overflow rules still apply.
  - S_DONE: clear_done=1 for one cycle, fb_write=0, then return to S_IDLE.
- Handshake: while fb_write is high and fb_ready is low, fb_address and fb_colour hold stable.
- A clear_req received while a clear is already pending or in progress is ignored.
- Latency: a strobe presented at edge N can appear on fb_write in the cycle after edge N+1.
- Throughput: one pixel per cycle when fb_ready is held high.

Optional Feature:
- Macro: PIXEL_RX_TRANSPARENT_KEY_EN.
- When defined: an on-screen pixel with rgb_bus == 24'hFF00FF (magenta key) is discarded before the FIFO. It sets neither clipped nor overflow.
- When undefined: magenta is written like any other colour.

Decomposition:
- Shared package pixel_bus_pkg holds:
  - screen-size constants;
  - the transparent key constant 24'hFF00FF;
  - the FSM state encoding (S_IDLE, S_CLEAR, S_DONE);
  - the helper for the colour-reduction width.
- Sub-module pixel_fifo: synchronous show-ahead FIFO with parameterised width and depth, push/pop/full/empty/count, asynchronous reset.

Test Plan:
1. Single pixel: strobe at x=3, y=2, rgb=FF8040, fb_ready=1. Expect exactly one fb_write with address 323 and colour 9'b111_100_010, visible 2 cycles after the strobe.
2. Clip: strobe at x=160, y=5. Expect clipped to pulse once, no fb_write, fifo_count stays 0.
3. Backpressure: fb_ready=0, 10 consecutive on-screen strobes. Expect fifo_count=8 and overflow=1. Then raise fb_ready: exactly 8 writes come out in strobe order, and overflow stays 1.
4. Clear: clear_req with colour 9'h0AA while 2 pixels are queued. Expect the 2 pixels written first, then 19200 writes to addresses 0..19199 with colour 0AA, then a single clear_done pulse.
5. Reset mid-clear: assert reset at clear address 500. Expect all outputs at reset values immediately. After release, no further writes and no clear_done.
6. With PIXEL_RX_TRANSPARENT_KEY_EN: strobe rgb=FF00FF. Expect no write, fifo_count stays 0. Without the macro: expect a write with colour 9'b111_000_111.
